mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF) and the
//  MEM stage (load/store). Serialises word, halfword and byte accesses into byte
//  cycles on the RAM port. Returns assembled data with a one-cycle done pulse.
//  Sits between if_stage/mem_stage and the RAM. Its busy outputs feed the stall
//  controller that drives the 6-bit stall vector to the pipeline registers.
// PARAMETERS
//  ADDR_W   32  address width, shared by the requester ports and the RAM port
// PORTS
//  clk_in        in   1       clock; all state changes on posedge
//  rst_in        in   1       reset, asynchronous, active-low
//  rdy_in        in   1       0 = freeze all state; mem_wr forced 0
//  flush_in      in   1       branch mispredict: cancel pending IF transaction
//  if_req        in   1       IF fetch request; held until if_done
//  if_addr       in   ADDR_W  fetch address; always 4 bytes
//  if_done       out  1       1-cycle pulse; if_data valid in the same cycle
//  if_data       out  32      fetched word, little-endian
//  mem_req       in   1       load/store request; held until mem_done
//  mem_we        in   1       1 = store, 0 = load
//  mem_len       in   3       access size in bytes: 1, 2 or 4; other values read as 4
//  mem_addr      in   ADDR_W  access address
//  mem_wdata     in   32      store data; low mem_len bytes are written
//  mem_done      out  1       1-cycle pulse; mem_rdata valid in the same cycle
//  mem_rdata     out  32      load data, zero-extended (mem_stage sign-extends)
//  if_busy       out  1       IF request pending and not yet done
//  mem_busy      out  1       MEM request pending and not yet done
//  ram_a         out  ADDR_W  RAM byte address
//  ram_dout      out  8       RAM write data
//  ram_wr        out  1       1 = write cycle
//  ram_din       in   8       RAM read data; valid one cycle after its address
// BEHAVIOUR
//  Reset values:
//  - every output 0; state IDLE; cnt 0; byte buffer 0.
//  States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
//  - IDLE: mem_req has priority over if_req (older instruction).
//    Latch addr, len, wdata and go to MEM_RD/MEM_WR, or to IF_RD with len=4.
//  - No preemption once a transaction starts.
//  Read of N bytes (request accepted at edge 0):
//  - ram_a = base+k during cycle k+1, for k = 0..N-1.
//  - ram_din captured into byte k at edge k+2.
//  - done high during cycle N+2 (4-byte fetch: if_done in cycle 6).
//  Write of N bytes:
//  - ram_wr=1 with ram_a=base+k and ram_dout=wdata[8k+7:8k] in cycle k+1.
//  - mem_done high in cycle N+1.
//  DONE state:
//  - Lasts exactly one cycle. The done pulse and data are registered outputs.
//  - No request is accepted in this cycle, so a requester that drops req late
//    is not re-served.
//  - Next state is IDLE.
//  Data and byte order:
//  - if_data/mem_rdata hold their last value until the next done.
//  - Byte 0 is at the lowest address (little-endian).
//  - Address arithmetic wraps modulo 2^ADDR_W.
//  flush_in:
//  - In IF_RD: abort to IDLE next edge, ram_wr stays 0, no if_done.
//  - In IDLE with only if_req: no grant that edge.
//  - No effect on MEM transactions.
//  rdy_in=0: state, cnt and outputs hold; ram_wr=0. Resume continues the same byte.
//  Busy outputs:
//  - if_busy = if_req & ~if_done.
//  - mem_busy = mem_req & ~mem_done.
//  - Both are combinational.
//  Reset mid-transaction: immediate return to IDLE, no done pulse.
//  The requester re-issues.
// STRUCTURE
//  Shared package/defines.v:
//  - state encodings ARB_IDLE..ARB_DONE, `ZeroWord, `WriteEnable/`WriteDisable.
//  - length codes LEN_B=1, LEN_H=2, LEN_W=4.
//  Single module. Internals: state register, 3-bit cnt, 4x8 byte buffer,
//  latched base/len/wdata. No sub-module is needed.
// TESTING
//  1. if_req, if_addr=0x100, RAM[0x100..0x103]=11,22,33,44
//     -> ram_a 0x100..0x103 in cycles 1..4; if_done cycle 6; if_data=0x44332211.
//  2. mem_req and if_req both high in IDLE
//     -> MEM served first; IF served after DONE; neither done is dropped.
//  3. Store, mem_len=2, addr=0x200, wdata=0xAABBCCDD
//     -> ram_wr cycles 1-2, bytes DD@0x200 then CC@0x201; mem_done cycle 3.
//  4. Load, mem_len=1 at 0x300 holding 0xF0
//     -> mem_rdata=0x000000F0; mem_done cycle 3.
//  5. flush_in in cycle 3 of an IF read
//     -> no if_done; IDLE next edge; a following MEM load completes normally.
//  6. rdy_in=0 for 3 cycles mid-write, then rst_in low mid-read
//     -> write resumes at the same byte with no extra ram_wr;
//        reset clears all outputs immediately.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, access length
// codes and small constants used when building RAM byte cycles.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_IF_RD,
      ARB_MEM_RD,
      ARB_MEM_WR,
      ARB_DONE
   } arb_state_e;

   localparam logic [2:0]  LEN_B        = 3'd1;
   localparam logic [2:0]  LEN_H        = 3'd2;
   localparam logic [2:0]  LEN_W        = 3'd4;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;

   // Any length code other than byte or halfword is treated as a full word.
   function automatic logic [2:0] decodeLen(input logic [2:0] lenCode);
      case (lenCode)
         LEN_B:   return LEN_B;
         LEN_H:   return LEN_H;
         default: return LEN_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the MEM stage,
// splitting word/halfword/byte accesses into one RAM byte cycle per byte.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [2:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   output logic              if_busy,
   output logic              mem_busy,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   input  logic [7:0]        ram_din
);

   arb_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0][7:0]   wdata_q, wdata_d;
   logic [3:0][7:0]   byteBuf_q, byteBuf_d;
   logic [ADDR_W-1:0] ramA_q, ramA_d;
   logic [7:0]        ramDout_q, ramDout_d;
   logic              ramWr_q, ramWr_d;
   logic              ifDone_q, ifDone_d;
   logic [31:0]       ifData_q, ifData_d;
   logic              memDone_q, memDone_d;
   logic [31:0]       memRdata_q, memRdata_d;

   logic [1:0]        byteIdx;
   logic [1:0]        nextIdx;
   logic [3:0][7:0]   capturedWord;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ARB_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         base_q     <= '0;
         wdata_q    <= ZeroWord;
         byteBuf_q  <= ZeroWord;
         ramA_q     <= '0;
         ramDout_q  <= '0;
         ramWr_q    <= WriteDisable;
         ifDone_q   <= 1'b0;
         ifData_q   <= ZeroWord;
         memDone_q  <= 1'b0;
         memRdata_q <= ZeroWord;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         byteBuf_q  <= byteBuf_d;
         ramA_q     <= ramA_d;
         ramDout_q  <= ramDout_d;
         ramWr_q    <= ramWr_d;
         ifDone_q   <= ifDone_d;
         ifData_q   <= ifData_d;
         memDone_q  <= memDone_d;
         memRdata_q <= memRdata_d;
      end
   end

   // In read states cnt counts edges since the grant; ram_din always carries
   // the byte addressed one cycle earlier, i.e. byte cnt-1.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      byteBuf_d    = byteBuf_q;
      ramA_d       = ramA_q;
      ramDout_d    = ramDout_q;
      ramWr_d      = ramWr_q;
      ifDone_d     = ifDone_q;
      ifData_d     = ifData_q;
      memDone_d    = memDone_q;
      memRdata_d   = memRdata_q;
      byteIdx      = 2'(cnt_q - 3'd1);
      nextIdx      = 2'(cnt_q + 3'd1);
      capturedWord = byteBuf_q;
      capturedWord[byteIdx] = ram_din;

      if (rdy_in) begin
         ifDone_d  = 1'b0;
         memDone_d = 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (mem_req) begin
                  base_d    = mem_addr;
                  len_d     = decodeLen(mem_len);
                  wdata_d   = mem_wdata;
                  cnt_d     = '0;
                  byteBuf_d = ZeroWord;
                  ramA_d    = mem_addr;
                  if (mem_we) begin
                     state_d   = ARB_MEM_WR;
                     ramDout_d = mem_wdata[7:0];
                     ramWr_d   = WriteEnable;
                  end else begin
                     state_d   = ARB_MEM_RD;
                  end
               end else if (if_req && !flush_in) begin
                  base_d    = if_addr;
                  len_d     = LEN_W;
                  cnt_d     = '0;
                  byteBuf_d = ZeroWord;
                  ramA_d    = if_addr;
                  state_d   = ARB_IF_RD;
               end
            end
            ARB_IF_RD, ARB_MEM_RD: begin
               if (state_q == ARB_IF_RD && flush_in) begin
                  state_d = ARB_IDLE;
                  cnt_d   = '0;
               end else begin
                  if (cnt_q != 3'd0) begin
                     byteBuf_d = capturedWord;
                  end
                  if (cnt_q == len_q) begin
                     state_d = ARB_DONE;
                     cnt_d   = '0;
                     if (state_q == ARB_IF_RD) begin
                        ifDone_d = 1'b1;
                        ifData_d = capturedWord;
                     end else begin
                        memDone_d  = 1'b1;
                        memRdata_d = capturedWord;
                     end
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                     if (cnt_q + 3'd1 < len_q) begin
                        ramA_d = base_q + ADDR_W'(cnt_q + 3'd1);
                     end
                  end
               end
            end
            ARB_MEM_WR: begin
               if (cnt_q + 3'd1 < len_q) begin
                  cnt_d     = cnt_q + 3'd1;
                  ramA_d    = base_q + ADDR_W'(cnt_q + 3'd1);
                  ramDout_d = wdata_q[nextIdx];
                  ramWr_d   = WriteEnable;
               end else begin
                  cnt_d     = '0;
                  ramWr_d   = WriteDisable;
                  memDone_d = 1'b1;
                  state_d   = ARB_DONE;
               end
            end
            ARB_DONE: begin
               state_d = ARB_IDLE;
            end
            default: begin
               state_d = ARB_IDLE;
            end
         endcase
      end
   end

   // A frozen write cycle is replayed on resume, so the strobe is masked rather than cleared.
   assign ram_wr    = ramWr_q & rdy_in;
   assign ram_a     = ramA_q;
   assign ram_dout  = ramDout_q;
   assign if_done   = ifDone_q;
   assign if_data   = ifData_q;
   assign mem_done  = memDone_q;
   assign mem_rdata = memRdata_q;
   assign if_busy   = if_req & ~ifDone_q;
   assign mem_busy  = mem_req & ~memDone_q;

endmodule
